// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by both the transmitter and the receiver:
// frame length, default clock rate, FSM state encodings and timing helpers.
package ps2_pkg;

    localparam int unsigned PS2_F_CLK  = 100_000_000;
    localparam int unsigned PACKET_LEN = 11;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_END
    } ps2_state_e;

    function automatic longint unsigned us_to_cycles(input int unsigned us,
                                                     input int unsigned f_clk);
        return (longint'(us) * longint'(f_clk)) / 64'd1_000_000;
    endfunction

endpackage

// File: rtl/ps2_host_to_dev_sync.sv
// Two-flop synchronizer for one raw PS/2 line; resets to the idle (high) level.
module ps2_host_to_dev_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= {2{RST_VAL}};
        end else begin
            ff_q <= {ff_q[0], async_i};
        end
    end

    assign sync_o = ff_q[1];

endmodule

// File: rtl/ps2_host_to_dev.sv
// PS/2 host-to-device byte transmitter: inhibits the clock, issues the request,
// shifts data/parity/stop on device falling edges and samples the ACK bit.
module ps2_host_to_dev
    import ps2_pkg::*;
#(
    parameter int unsigned F_CLK           = PS2_F_CLK,
    parameter int unsigned INHIBIT_US      = 100,
    parameter int unsigned REQ_TIMEOUT_US  = 15000,
    parameter int unsigned EDGE_TIMEOUT_US = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    input  logic [7:0] tx_data,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam longint unsigned INH_CYC  = us_to_cycles(INHIBIT_US, F_CLK);
    localparam longint unsigned REQ_CYC  = us_to_cycles(REQ_TIMEOUT_US, F_CLK);
    localparam longint unsigned EDGE_CYC = us_to_cycles(EDGE_TIMEOUT_US, F_CLK);
    localparam longint unsigned MAX_A    = (INH_CYC > REQ_CYC) ? INH_CYC : REQ_CYC;
    localparam longint unsigned MAX_CYC  = (MAX_A > EDGE_CYC) ? MAX_A : EDGE_CYC;
    localparam int              CNT_W    = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INH_CYC - 1);
    localparam logic [CNT_W-1:0] REQ_LAST  = CNT_W'(REQ_CYC - 1);
    localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(EDGE_CYC - 1);
    localparam logic [3:0]       STOP_EDGE = 4'(PACKET_LEN - 2);

    ps2_state_e       state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, wd_last;
    logic [3:0]       bit_q;
    logic [8:0]       shift_q;
    logic             nack_q, clk_prev_q;
    logic             clk_low_q, data_low_q, busy_q, done_q, err_q;
    logic             clk_s, data_s, fall, rise, wd_expired;

    ps2_host_to_dev_sync #(.RST_VAL(1'b1)) u_sync_clk (
        .clk    (clk),
        .rst    (rst),
        .async_i(ps2_clk),
        .sync_o (clk_s)
    );

    ps2_host_to_dev_sync #(.RST_VAL(1'b1)) u_sync_data (
        .clk    (clk),
        .rst    (rst),
        .async_i(ps2_data),
        .sync_o (data_s)
    );

    assign fall       = clk_prev_q & ~clk_s;
    assign rise       = ~clk_prev_q & clk_s;
    // Any device clock activity restarts the watchdog.
    assign cnt_d      = (fall | rise) ? '0 : cnt_q + 1'b1;
    assign wd_last    = (state_q == REQ) ? REQ_LAST : EDGE_LAST;
    assign wd_expired = (cnt_q == wd_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            nack_q     <= 1'b0;
            clk_prev_q <= 1'b1;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_prev_q <= clk_s;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_low_q  <= 1'b0;
                    data_low_q <= 1'b0;
                    if (start) begin
                        shift_q   <= {~^tx_data, tx_data};
                        bit_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        clk_low_q <= 1'b1;
                        state_q   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        clk_low_q  <= 1'b0;
                        data_low_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= REQ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (wd_expired) begin
                        clk_low_q  <= 1'b0;
                        data_low_q <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        bit_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        case (state_q)
                            REQ, DATA: begin
                                // Edge 1 arrives in REQ; edges 2..10 in DATA.
                                if (fall) begin
                                    bit_q <= bit_q + 4'd1;
                                    if (bit_q == STOP_EDGE) begin
                                        data_low_q <= 1'b0;
                                        state_q    <= ACK;
                                    end else begin
                                        data_low_q <= ~shift_q[0];
                                        shift_q    <= {1'b0, shift_q[8:1]};
                                        state_q    <= DATA;
                                    end
                                end
                            end
                            ACK: begin
                                if (fall) begin
                                    nack_q  <= data_s;
                                    bit_q   <= bit_q + 4'd1;
                                    state_q <= WAIT_END;
                                end
                            end
                            WAIT_END: begin
                                if (clk_s && data_s) begin
                                    done_q  <= 1'b1;
                                    err_q   <= nack_q;
                                    busy_q  <= 1'b0;
                                    state_q <= IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign ps2_clk_low  = clk_low_q;
    assign ps2_data_low = data_low_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule
